// File: rtl/evm_ballot_ctrl.sv
// EVM ballot front-end: debounces the voter button, arms one ballot per officer issue,
// validates a one-hot party selection and emits a single-cycle vote strobe with running totals.
module evm_ballot_ctrl #(
   parameter int unsigned DEB_CYCLES = 16,
   parameter int unsigned INV_W      = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             voting_en,
   input  logic             ballot_issue,
   input  logic [3:0]       voter_switch,
   input  logic             Push_Button,
   output logic             vote_pulse,
   output logic [3:0]       vote_party,
   output logic             ready,
   output logic [6:0]       votes_cast,
   output logic [INV_W-1:0] invalid_cnt
);

   localparam int unsigned CNT_W     = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned VOTES_W   = 7;
   localparam logic [VOTES_W-1:0] VOTES_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CHECK,
      ST_WAIT_REL_A,
      ST_CAST,
      ST_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_n;
   logic               r_sync1;
   logic               r_sync2;
   logic               r_btn_state;
   logic               r_btn_prev;
   logic [CNT_W-1:0]   r_deb_cnt;
   logic [3:0]         r_sel_q;
   logic               r_vote_pulse;
   logic [3:0]         r_vote_party;
   logic               r_ready;
   logic [VOTES_W-1:0] r_votes_cast;
   logic [INV_W-1:0]   r_invalid_cnt;
   logic               w_press;
   logic               w_rel;
   logic               w_sel_onehot;
   logic               w_sel_load;
   logic               w_inv_inc;

   // Button synchronizer and debouncer: a level change must hold for DEB_CYCLES samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_btn_state <= 1'b0;
         r_btn_prev  <= 1'b0;
         r_deb_cnt   <= '0;
      end else begin
         r_sync1    <= Push_Button;
         r_sync2    <= r_sync1;
         r_btn_prev <= r_btn_state;
         if (r_sync2 != r_btn_state) begin
            if (r_deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
               r_btn_state <= ~r_btn_state;
               r_deb_cnt   <= '0;
            end else begin
               r_deb_cnt <= r_deb_cnt + CNT_W'(1);
            end
         end else begin
            r_deb_cnt <= '0;
         end
      end
   end

   assign w_press      = r_btn_state & ~r_btn_prev;
   assign w_rel        = ~r_btn_state;
   assign w_sel_onehot = (r_sel_q != 4'd0) && ((r_sel_q & (r_sel_q - 4'd1)) == 4'd0);

   // Ballot sequencing; losing voting_en abandons an uncast ballot but never a pulse in flight.
   always_comb begin
      w_state_n  = r_state;
      w_sel_load = 1'b0;
      w_inv_inc  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (ballot_issue && voting_en) w_state_n = ST_ARMED;
         end
         ST_ARMED: begin
            if (!voting_en) begin
               w_state_n = ST_IDLE;
            end else if (w_press) begin
               w_state_n  = ST_CHECK;
               w_sel_load = 1'b1;
            end
         end
         ST_CHECK: begin
            if (!voting_en) begin
               w_state_n = ST_IDLE;
            end else if (w_sel_onehot) begin
               w_state_n = ST_CAST;
            end else begin
               w_state_n = ST_WAIT_REL_A;
               w_inv_inc = 1'b1;
            end
         end
         ST_WAIT_REL_A: begin
            if (!voting_en)  w_state_n = ST_IDLE;
            else if (w_rel)  w_state_n = ST_ARMED;
         end
         ST_CAST: begin
            w_state_n = ST_DONE;
         end
         ST_DONE: begin
            if (w_rel) w_state_n = ST_IDLE;
         end
         default: begin
            w_state_n = ST_IDLE;
         end
      endcase
   end

   // State register; outputs are registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_sel_q       <= 4'd0;
         r_vote_pulse  <= 1'b0;
         r_vote_party  <= 4'd0;
         r_ready       <= 1'b0;
         r_votes_cast  <= '0;
         r_invalid_cnt <= '0;
      end else begin
         r_state      <= w_state_n;
         r_vote_pulse <= (w_state_n == ST_CAST);
         r_ready      <= (w_state_n == ST_ARMED) || (w_state_n == ST_CHECK);
         if (w_sel_load) r_sel_q <= voter_switch;
         if (w_state_n == ST_CAST) begin
            r_vote_party <= r_sel_q;
            if (r_votes_cast != VOTES_MAX) r_votes_cast <= r_votes_cast + VOTES_W'(1);
         end
         if (w_inv_inc && (r_invalid_cnt != {INV_W{1'b1}}))
            r_invalid_cnt <= r_invalid_cnt + INV_W'(1);
      end
   end

   assign vote_pulse  = r_vote_pulse;
   assign vote_party  = r_vote_party;
   assign ready       = r_ready;
   assign votes_cast  = r_votes_cast;
   assign invalid_cnt = r_invalid_cnt;

endmodule
